reg_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard and forwarding unit for the decode stage. Per architectural register, it counts in-flight writers between issue (decode to execute handshake) and retire (writeback) or cancel. It also selects forwarded operands from N pipeline stages, youngest first. Decode supplies its register-file read data and consumes the resolved operands plus a single issue-stall, replacing hand-written per-stage compare logic.

---
 rtl/reg_scoreboard_pkg.sv | 26 ++
 rtl/sb_fwd_mux.sv | 60 ++++++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants and types for the register scoreboard
package reg_scoreboard_pkg;

  localparam int SB_NREG = 32;
  localparam int SB_DW   = 32;
  localparam int SB_NSTG = 3;
  localparam int SB_CW   = 2;
  localparam int SB_NRD  = 2;
  localparam int SB_AW   = $clog2(SB_NREG);

  // Field widths follow the default configuration.
  typedef struct packed {
    logic              valid;
    logic [SB_AW-1:0]  dest;
    logic              ready;
    logic [SB_DW-1:0]  data;
  } fwd_stage_t;

  typedef enum logic [1:0] {
    RES_ZERO,
    RES_FWD,
    RES_RF,
    RES_STALL
  } res_t;

endpackage

// File: rtl/sb_fwd_mux.sv
// rtl/sb_fwd_mux.sv - one read port's youngest-first forwarding match and operand select
module sb_fwd_mux
  import reg_scoreboard_pkg::*;
#(
  parameter int AW   = SB_AW,
  parameter int DW   = SB_DW,
  parameter int NSTG = SB_NSTG
) (
  input  logic                resetn,
  input  logic [AW-1:0]       addr,
  input  logic                en,
  input  logic [DW-1:0]       rf_rdata,
  input  logic                pend_busy,
  input  logic [NSTG-1:0]     fwd_valid,
  input  logic [NSTG*AW-1:0]  fwd_dest,
  input  logic [NSTG-1:0]     fwd_ready,
  input  logic [NSTG*DW-1:0]  fwd_data,
  output logic [DW-1:0]       data,
  output logic                stall
);

  logic          hit;
  logic          hit_ready;
  logic [DW-1:0] hit_data;
  res_t          res;

  // Scan oldest to youngest so the youngest matching stage overwrites the others.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (fwd_valid[s] && (fwd_dest[s*AW +: AW] == addr)) begin
        hit       = 1'b1;
        hit_ready = fwd_ready[s];
        hit_data  = fwd_data[s*DW +: DW];
      end
    end
  end

  always_comb begin
    res = RES_RF;
    if (addr == '0)     res = RES_ZERO;
    else if (!resetn)   res = RES_RF;
    else if (hit)       res = hit_ready ? RES_FWD : RES_STALL;
    else if (pend_busy) res = RES_STALL;
  end

  always_comb begin
    data = rf_rdata;
    case (res)
      RES_ZERO: data = '0;
      RES_FWD:  data = hit_data;
      default:  data = rf_rdata;
    endcase
  end

  assign stall = en && (res == RES_STALL);

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight writer counters plus operand forwarding for decode
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG = SB_NREG,
  parameter int AW   = $clog2(NREG),
  parameter int DW   = SB_DW,
  parameter int NRD  = SB_NRD,
  parameter int NSTG = SB_NSTG,
  parameter int CW   = SB_CW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*DW-1:0]   rf_rdata,
  output logic [NRD*DW-1:0]   rd_data,
  input  logic [NSTG-1:0]     fwd_valid,
  input  logic [NSTG*AW-1:0]  fwd_dest,
  input  logic [NSTG-1:0]     fwd_ready,
  input  logic [NSTG*DW-1:0]  fwd_data,
  input  logic                iss_fire,
  input  logic                iss_we,
  input  logic [AW-1:0]       iss_dest,
  input  logic                ret_fire,
  input  logic [AW-1:0]       ret_dest,
  input  logic                cnl_fire,
  input  logic [AW-1:0]       cnl_dest,
  output logic [NRD-1:0]      rd_stall,
  output logic                iss_stall
);

  localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

  logic [CW-1:0] pend_q   [1:NREG-1];
  logic [CW-1:0] pend_nxt [1:NREG-1];
  logic          iss_inc, ret_dec, cnl_dec, underflow;
  logic          iss_wants, iss_full;
  logic [CW-1:0] iss_pend;
  logic [CW-1:0] rd_pend  [NRD];

  function automatic logic [CW-1:0] pend_of(input logic [AW-1:0] a);
    return (a == '0) ? '0 : pend_q[a];
  endfunction

  assign iss_inc = iss_fire && iss_we && (iss_dest != '0);
  assign ret_dec = ret_fire && (ret_dest != '0);
  assign cnl_dec = cnl_fire && (cnl_dest != '0);

  // Net effect of all events per register; an illegal underflow clamps at zero.
  always_comb begin
    logic [CW+1:0] sum;
    logic [CW+1:0] dec;
    underflow = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      sum = (CW+2)'(pend_q[r]) + (CW+2)'(iss_inc && (iss_dest == AW'(r)));
      dec = (CW+2)'(ret_dec && (ret_dest == AW'(r)))
          + (CW+2)'(cnl_dec && (cnl_dest == AW'(r)));
      if (sum < dec) begin
        pend_nxt[r] = '0;
        underflow   = 1'b1;
      end else begin
        pend_nxt[r] = CW'(sum - dec);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= pend_nxt[r];
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) rd_pend[p] = pend_of(rd_addr[p*AW +: AW]);
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    sb_fwd_mux #(
      .AW   (AW),
      .DW   (DW),
      .NSTG (NSTG)
    ) u_mux (
      .resetn    (resetn),
      .addr      (rd_addr[p*AW +: AW]),
      .en        (rd_en[p]),
      .rf_rdata  (rf_rdata[p*DW +: DW]),
      .pend_busy (rd_pend[p] != '0),
      .fwd_valid (fwd_valid),
      .fwd_dest  (fwd_dest),
      .fwd_ready (fwd_ready),
      .fwd_data  (fwd_data),
      .data      (rd_data[p*DW +: DW]),
      .stall     (rd_stall[p])
    );
  end

  assign iss_pend  = pend_of(iss_dest);
  assign iss_wants = iss_we && (iss_dest != '0);
  assign iss_full  = iss_wants && (iss_pend == PEND_MAX);
  assign iss_stall = resetn && ((|rd_stall) || iss_full);

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn) !underflow);
  a_no_fire_on_stall: assert property (@(posedge clk) disable iff (!resetn) !(iss_fire && iss_stall));

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed bench with a per-cycle behavioural model of the scoreboard
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int NREG = SB_NREG;
  localparam int AW   = SB_AW;
  localparam int DW   = SB_DW;
  localparam int NRD  = SB_NRD;
  localparam int NSTG = SB_NSTG;
  localparam int CW   = SB_CW;
  localparam int PMAX = (1 << CW) - 1;

  logic                clk;
  logic                resetn;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_en;
  logic [NRD*DW-1:0]   rf_rdata;
  logic [NRD*DW-1:0]   rd_data;
  logic [NSTG-1:0]     fwd_valid;
  logic [NSTG*AW-1:0]  fwd_dest;
  logic [NSTG-1:0]     fwd_ready;
  logic [NSTG*DW-1:0]  fwd_data;
  logic                iss_fire, iss_we, ret_fire, cnl_fire;
  logic [AW-1:0]       iss_dest, ret_dest, cnl_dest;
  logic [NRD-1:0]      rd_stall;
  logic                iss_stall;

  fwd_stage_t          stg    [NSTG];
  logic [AW-1:0]       a_addr [NRD];
  logic [DW-1:0]       a_rf   [NRD];
  int                  m_pend [NREG];
  int                  n_vec;
  int                  n_err;

  reg_scoreboard #(
    .NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NSTG(NSTG), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rd_addr(rd_addr), .rd_en(rd_en), .rf_rdata(rf_rdata), .rd_data(rd_data),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .iss_fire(iss_fire), .iss_we(iss_we), .iss_dest(iss_dest),
    .ret_fire(ret_fire), .ret_dest(ret_dest),
    .cnl_fire(cnl_fire), .cnl_dest(cnl_dest),
    .rd_stall(rd_stall), .iss_stall(iss_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fwd_valid = '0; fwd_dest = '0; fwd_ready = '0; fwd_data = '0;
    rd_addr = '0; rf_rdata = '0;
    for (int s = 0; s < NSTG; s++) begin
      fwd_valid[s]          = stg[s].valid;
      fwd_dest[s*AW +: AW]  = stg[s].dest;
      fwd_ready[s]          = stg[s].ready;
      fwd_data[s*DW +: DW]  = stg[s].data;
    end
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p*AW +: AW]  = a_addr[p];
      rf_rdata[p*DW +: DW] = a_rf[p];
    end
  end

  // Counts are plain integers: add issues, subtract retires and cancels, floor at zero.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    end else begin
      int d [NREG];
      for (int r = 0; r < NREG; r++) d[r] = 0;
      if (iss_fire && iss_we && iss_dest != 0) d[iss_dest] += 1;
      if (ret_fire && ret_dest != 0) d[ret_dest] -= 1;
      if (cnl_fire && cnl_dest != 0) d[cnl_dest] -= 1;
      for (int r = 1; r < NREG; r++) m_pend[r] = (m_pend[r] + d[r] < 0) ? 0 : m_pend[r] + d[r];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_port(input int p, output logic [DW-1:0] d, output logic blocked);
    logic found;
    found   = 1'b0;
    blocked = 1'b0;
    d       = a_rf[p];
    if (a_addr[p] == 0) begin
      d = '0;
    end else if (resetn) begin
      for (int s = 0; s < NSTG; s++) begin
        if (!found && stg[s].valid && stg[s].dest == a_addr[p]) begin
          found = 1'b1;
          if (stg[s].ready) d = stg[s].data;
          else blocked = 1'b1;
        end
      end
      if (!found && m_pend[a_addr[p]] != 0) blocked = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic          b;
    logic          any;
    any = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      model_port(p, d, b);
      check($sformatf("cyc rd_stall[%0d]", p), 64'(rd_stall[p]), 64'(b && rd_en[p]));
      if (!b) check($sformatf("cyc rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(d));
      any = any | (b && rd_en[p]);
    end
    check("cyc iss_stall", 64'(iss_stall),
          64'(resetn && (any || (iss_we && iss_dest != 0 && m_pend[iss_dest] == PMAX))));
  end

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic idle;
    for (int s = 0; s < NSTG; s++) stg[s] = '0;
    for (int p = 0; p < NRD; p++) begin a_addr[p] = '0; a_rf[p] = '0; end
    rd_en = '0;
    iss_fire = 0; iss_we = 0; iss_dest = '0;
    ret_fire = 0; ret_dest = '0; cnl_fire = 0; cnl_dest = '0;
  endtask

  task automatic issue(input int d);
    logic [NRD-1:0] save;
    save = rd_en; rd_en = '0;
    iss_fire = 1; iss_we = 1; iss_dest = AW'(d);
    cyc;
    iss_fire = 0; iss_we = 0; rd_en = save;
  endtask

  task automatic retire(input int d);
    ret_fire = 1; ret_dest = AW'(d);
    cyc;
    ret_fire = 0;
  endtask

  function automatic logic [DW-1:0] rdp(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  initial begin
    n_vec = 0; n_err = 0;
    resetn = 0;
    idle;
    // reset: register file passes through, r0 reads zero, forwarding is ignored
    a_addr[0] = 5; a_rf[0] = 32'h1234; a_addr[1] = 0; a_rf[1] = 32'hFFFF;
    stg[0] = '{1'b1, 5'd0, 1'b1, 32'hDEAD};
    stg[1] = '{1'b1, 5'd5, 1'b0, 32'h0};
    rd_en = 2'b11;
    cyc;
    check("rst rd_data0", rdp(0), 32'h1234);
    check("rst rd_stall", 64'(rd_stall), 0);
    check("rst r0 data", rdp(1), 0);
    check("rst iss_stall", 64'(iss_stall), 0);
    cyc;
    resetn = 1;
    cyc;
    check("post rst r5 not ready", 64'(rd_stall[0]), 1);
    idle;

    // youngest stage wins; a not-ready youngest blocks older data
    rd_en = 2'b01; a_addr[0] = 7; a_rf[0] = 32'h77;
    stg[0] = '{1'b1, 5'd7, 1'b1, 32'hA};
    stg[2] = '{1'b1, 5'd7, 1'b1, 32'hC};
    cyc;
    check("prio data", rdp(0), 32'hA);
    stg[0].ready = 0;
    cyc;
    check("prio stall", 64'(rd_stall[0]), 1);
    check("prio iss_stall", 64'(iss_stall), 1);
    rd_en = 2'b00;
    cyc;
    check("unused port no stall", 64'(rd_stall[0]), 0);
    stg[1] = '{1'b1, 5'd8, 1'b1, 32'hB}; a_addr[1] = 8; rd_en = 2'b10;
    cyc;
    check("port1 mid stage", rdp(1), 32'hB);
    idle;

    // load-use
    issue(3);
    check("model pend r3", 64'(m_pend[3]), 1);
    stg[0] = '{1'b1, 5'd3, 1'b0, 32'h0}; a_addr[0] = 3; rd_en = 2'b01;
    cyc;
    check("load-use iss_stall", 64'(iss_stall), 1);
    stg[0].ready = 1; stg[0].data = 32'h55;
    cyc;
    check("load-use data", rdp(0), 32'h55);
    check("load-use no stall", 64'(iss_stall), 0);
    idle;
    retire(3);

    // writer in flight but not on any stage
    issue(9);
    a_addr[0] = 9; a_rf[0] = 32'h99; rd_en = 2'b01;
    cyc;
    check("invisible stall", 64'(rd_stall[0]), 1);
    retire(9);
    cyc;
    check("invisible rf", rdp(0), 32'h99);
    check("invisible no stall", 64'(rd_stall[0]), 0);
    idle;

    // saturation at 2^CW-1
    issue(4); issue(4); issue(4);
    check("model pend r4 sat", 64'(m_pend[4]), 3);
    iss_we = 1; iss_dest = 4;
    cyc;
    check("sat iss_stall", 64'(iss_stall), 1);
    iss_we = 0;
    retire(4);
    iss_fire = 1; iss_we = 1; iss_dest = 4; ret_fire = 1; ret_dest = 4;
    cyc;
    iss_fire = 0; iss_we = 0; ret_fire = 0;
    check("model pend r4 net", 64'(m_pend[4]), 2);
    issue(4);
    iss_we = 1; iss_dest = 4;
    cyc;
    check("net hold then full", 64'(iss_stall), 1);
    iss_we = 0;

    // retire plus cancel to one register subtracts two
    issue(6); issue(6);
    a_addr[0] = 6; a_rf[0] = 32'h66; rd_en = 2'b01;
    cyc;
    check("cancel pre stall", 64'(rd_stall[0]), 1);
    rd_en = 0;
    cnl_fire = 1; cnl_dest = 6; ret_fire = 1; ret_dest = 6;
    cyc;
    cnl_fire = 0; ret_fire = 0; rd_en = 2'b01;
    cyc;
    check("cancel cleared", 64'(rd_stall[0]), 0);
    check("cancel rf", rdp(0), 32'h66);

    // asynchronous reset mid-run discards all counts
    issue(10);
    a_addr[0] = 10; a_rf[0] = 32'h1010; rd_en = 2'b01;
    cyc;
    check("pre reset stall", 64'(rd_stall[0]), 1);
    #2 resetn = 0;
    #1;
    check("async rst stall", 64'(rd_stall[0]), 0);
    check("async rst data", rdp(0), 32'h1010);
    cyc;
    resetn = 1;
    iss_we = 1; iss_dest = 4;
    cyc;
    check("post rst r4 free", 64'(iss_stall), 0);
    check("post rst r10 rf", rdp(0), 32'h1010);
    idle;

    // both ports: r12 from oldest stage, r0 ignores a not-ready r0 writer
    stg[0] = '{1'b1, 5'd0, 1'b0, 32'h1};
    stg[1] = '{1'b1, 5'd13, 1'b1, 32'h2};
    stg[2] = '{1'b1, 5'd12, 1'b1, 32'hC0DE};
    a_addr[0] = 12; a_addr[1] = 0; a_rf[1] = 32'h5; rd_en = 2'b11;
    cyc;
    check("two-port p0", rdp(0), 32'hC0DE);
    check("two-port p1", rdp(1), 0);
    check("two-port stall", 64'(iss_stall), 0);
    idle;
    cyc;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
